// File: rtl/sram_like_arbiter_pkg.sv
// Shared CPU bus package: bus widths, transfer size encodings and
// arbitration mode constants used by the SRAM-like arbiter.
package sram_like_arbiter_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order ID FIFO: remembers which channel issued each outstanding
// transaction so responses can be routed back in issue order.
module id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_id,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_id,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign count   = count_q;
  assign head_id = mem_q[rd_ptr_q];

  // Next-state for storage, pointers (wrapping naturally) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Multi-master SRAM-like bus arbiter: grants one channel at a time to a
// single slave, limits outstanding transactions and routes in-order
// responses back through an ID FIFO.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_OUT  = 4,
  parameter int ARB_MODE = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        s_req,
  input  logic [NUM_CH-1:0]        s_wr,
  input  logic [2*NUM_CH-1:0]      s_size,
  input  logic [ADDR_W*NUM_CH-1:0] s_addr,
  input  logic [DATA_W*NUM_CH-1:0] s_wdata,
  output logic [NUM_CH-1:0]        s_addr_ok,
  output logic [NUM_CH-1:0]        s_data_ok,
  output logic [DATA_W-1:0]        s_rdata,
  output logic                     m_req,
  output logic                     m_wr,
  output logic [1:0]               m_size,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic                     m_addr_ok,
  input  logic                     m_data_ok,
  input  logic [DATA_W-1:0]        m_rdata,
  output logic                     err
);

  localparam int ID_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  logic [ID_W-1:0]  grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  arb_ch, grant, head_id, cand;
  logic             lock_q, lock_d, err_q, err_d;
  logic             arb_found, lock_held, lock_drop, handshake, pop;
  logic             fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  int               arb_start, cand_sum;

  // Next-grant search: fixed priority from 0, or round-robin from rr_ptr.
  always_comb begin
    arb_ch    = '0;
    arb_found = 1'b0;
    cand      = '0;
    cand_sum  = 0;
    arb_start = (ARB_MODE == ARB_RR) ? int'(rr_ptr_q) : 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_sum = arb_start + i;
      if (cand_sum >= NUM_CH) cand_sum = cand_sum - NUM_CH;
      cand = ID_W'(cand_sum);
      if (!arb_found && s_req[cand]) begin
        arb_ch    = cand;
        arb_found = 1'b1;
      end
    end
  end

  assign lock_held = lock_q & s_req[grant_q];
  assign lock_drop = lock_q & ~s_req[grant_q];
  assign grant     = lock_held ? grant_q : arb_ch;
  assign m_req     = resetn & (|s_req) & ~fifo_full;
  assign handshake = m_req & m_addr_ok;
  assign pop       = resetn & m_data_ok & ~fifo_empty;
  assign s_rdata   = m_rdata;
  assign err       = err_q;

  // Slave-side mux and per-channel accept/response strobes.
  always_comb begin
    m_wr      = 1'b0;
    m_size    = '0;
    m_addr    = '0;
    m_wdata   = '0;
    s_addr_ok = '0;
    s_data_ok = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant == ID_W'(c)) begin
        m_wr    = s_wr[c];
        m_size  = s_size[2*c +: 2];
        m_addr  = s_addr[ADDR_W*c +: ADDR_W];
        m_wdata = s_wdata[DATA_W*c +: DATA_W];
      end
      s_addr_ok[c] = handshake & (grant == ID_W'(c));
      s_data_ok[c] = pop & (head_id == ID_W'(c));
    end
  end

  // Lock holds the grant until accepted; rr pointer moves past the winner.
  always_comb begin
    grant_d  = grant_q;
    lock_d   = lock_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q | lock_drop | (m_data_ok & fifo_empty);
    if (handshake) begin
      lock_d   = 1'b0;
      rr_ptr_d = (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end else if (m_req) begin
      lock_d  = 1'b1;
      grant_d = grant;
    end else begin
      lock_d = 1'b0;
    end
  end

  // Arbiter state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q  <= '0;
      lock_q   <= 1'b0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      lock_q   <= lock_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  id_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (ID_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (handshake),
    .push_id (grant),
    .pop     (pop),
    .head_id (head_id),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter driven
// by directed scenarios and protocol-conforming random traffic, compared
// against a queue-based behavioural model.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MO  = 4;

  logic clk = 1'b0;
  logic resetn;

  logic [NCH-1:0]    s_req     [2];
  logic [NCH-1:0]    s_wr      [2];
  logic [2*NCH-1:0]  s_size    [2];
  logic [AW*NCH-1:0] s_addr    [2];
  logic [DW*NCH-1:0] s_wdata   [2];
  logic              m_addr_ok [2];
  logic              m_data_ok [2];
  logic [DW-1:0]     m_rdata   [2];
  logic [NCH-1:0]    s_addr_ok [2];
  logic [NCH-1:0]    s_data_ok [2];
  logic [DW-1:0]     s_rdata   [2];
  logic              m_req     [2];
  logic              m_wr      [2];
  logic [1:0]        m_size    [2];
  logic [AW-1:0]     m_addr    [2];
  logic [DW-1:0]     m_wdata   [2];
  logic              err       [2];

  int check_count = 0;
  int pass_count  = 0;

  // model state (index 0 = round-robin instance, 1 = fixed priority)
  int rr_next [2];
  bit locked  [2];
  int lock_ch [2];
  bit merr    [2];
  int q0 [$];
  int q1 [$];

  // per-cycle predictions
  bit p_mreq [2];
  bit p_push [2];
  bit p_pop  [2];
  bit p_drop [2];
  bit p_emptyhit [2];
  int p_g    [2];
  int p_head [2];

  bit acc [2][NCH];

  always #5 clk = ~clk;

  sram_like_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO), .ARB_MODE(ARB_RR)
  ) dut_rr (
    .clk(clk), .resetn(resetn),
    .s_req(s_req[0]), .s_wr(s_wr[0]), .s_size(s_size[0]), .s_addr(s_addr[0]),
    .s_wdata(s_wdata[0]), .s_addr_ok(s_addr_ok[0]), .s_data_ok(s_data_ok[0]),
    .s_rdata(s_rdata[0]), .m_req(m_req[0]), .m_wr(m_wr[0]), .m_size(m_size[0]),
    .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_addr_ok(m_addr_ok[0]),
    .m_data_ok(m_data_ok[0]), .m_rdata(m_rdata[0]), .err(err[0])
  );

  sram_like_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO), .ARB_MODE(ARB_FIXED)
  ) dut_fx (
    .clk(clk), .resetn(resetn),
    .s_req(s_req[1]), .s_wr(s_wr[1]), .s_size(s_size[1]), .s_addr(s_addr[1]),
    .s_wdata(s_wdata[1]), .s_addr_ok(s_addr_ok[1]), .s_data_ok(s_data_ok[1]),
    .s_rdata(s_rdata[1]), .m_req(m_req[1]), .m_wr(m_wr[1]), .m_size(m_size[1]),
    .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_addr_ok(m_addr_ok[1]),
    .m_data_ok(m_data_ok[1]), .m_rdata(m_rdata[1]), .err(err[1])
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic string nm(input int idx);
    return (idx == 0) ? "rr" : "fx";
  endfunction

  function automatic int qsz(input int idx);
    return (idx == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qhd(input int idx);
    return (idx == 0) ? q0[0] : q1[0];
  endfunction

  task automatic clear_model(input int idx);
    rr_next[idx] = 0;
    locked[idx]  = 1'b0;
    lock_ch[idx] = 0;
    merr[idx]    = 1'b0;
    if (idx == 0) q0.delete(); else q1.delete();
  endtask

  task automatic set_fields(input int idx, input int ch, input bit wr, input logic [1:0] sz,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    s_wr[idx][ch]             = wr;
    s_size[idx][ch*2 +: 2]    = sz;
    s_addr[idx][ch*AW +: AW]  = addr;
    s_wdata[idx][ch*DW +: DW] = wdata;
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] req, input bit aok, input bit dok,
                               input logic [DW-1:0] rdata);
    for (int idx = 0; idx < 2; idx++) begin
      s_req[idx]     = req;
      m_addr_ok[idx] = aok;
      m_data_ok[idx] = dok;
      m_rdata[idx]   = rdata;
    end
  endtask

  // behavioural prediction from the arbitration rules
  task automatic predict(input int idx);
    int qs, start, g;
    bit held;
    qs    = qsz(idx);
    start = (idx == 0) ? rr_next[idx] : 0;
    held  = locked[idx] && s_req[idx][lock_ch[idx]];
    p_drop[idx] = locked[idx] && !held;
    g = -1;
    if (held) g = lock_ch[idx];
    else begin
      for (int i = 0; i < NCH; i++) begin
        int c = (start + i) % NCH;
        if (g < 0 && s_req[idx][c]) g = c;
      end
    end
    p_g[idx]        = (g < 0) ? 0 : g;
    p_mreq[idx]     = resetn && (g >= 0) && (qs < MO);
    p_push[idx]     = p_mreq[idx] && m_addr_ok[idx];
    p_pop[idx]      = resetn && m_data_ok[idx] && (qs > 0);
    p_emptyhit[idx] = m_data_ok[idx] && (qs == 0);
    p_head[idx]     = (qs > 0) ? qhd(idx) : 0;
  endtask

  task automatic settle_and_check();
    logic [NCH-1:0] eaok, edok;
    int g;
    #2;
    for (int idx = 0; idx < 2; idx++) begin
      predict(idx);
      g    = p_g[idx];
      eaok = p_push[idx] ? (NCH'(1) << g) : '0;
      edok = p_pop[idx] ? (NCH'(1) << p_head[idx]) : '0;
      checkOutput({nm(idx), ".m_req"}, 64'(m_req[idx]), 64'(p_mreq[idx]));
      checkOutput({nm(idx), ".s_addr_ok"}, 64'(s_addr_ok[idx]), 64'(eaok));
      checkOutput({nm(idx), ".s_data_ok"}, 64'(s_data_ok[idx]), 64'(edok));
      checkOutput({nm(idx), ".err"}, 64'(err[idx]), 64'(resetn ? merr[idx] : 1'b0));
      if (p_pop[idx])
        checkOutput({nm(idx), ".s_rdata"}, 64'(s_rdata[idx]), 64'(m_rdata[idx]));
      if (p_mreq[idx]) begin
        checkOutput({nm(idx), ".m_addr"}, 64'(m_addr[idx]), 64'(s_addr[idx][g*AW +: AW]));
        checkOutput({nm(idx), ".m_wdata"}, 64'(m_wdata[idx]), 64'(s_wdata[idx][g*DW +: DW]));
        checkOutput({nm(idx), ".m_wr"}, 64'(m_wr[idx]), 64'(s_wr[idx][g]));
        checkOutput({nm(idx), ".m_size"}, 64'(m_size[idx]), 64'(s_size[idx][g*2 +: 2]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int idx = 0; idx < 2; idx++) begin
      if (!resetn) clear_model(idx);
      else begin
        if (p_drop[idx] || p_emptyhit[idx]) merr[idx] = 1'b1;
        if (p_pop[idx]) begin
          if (idx == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (p_push[idx]) begin
          if (idx == 0) q0.push_back(p_g[idx]); else q1.push_back(p_g[idx]);
          rr_next[idx] = (p_g[idx] + 1) % NCH;
          locked[idx]  = 1'b0;
        end else if (p_mreq[idx]) begin
          locked[idx]  = 1'b1;
          lock_ch[idx] = p_g[idx];
        end else begin
          locked[idx] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0, '0);
    settle_and_check();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b1;
    for (int idx = 0; idx < 2; idx++) begin
      clear_model(idx);
      s_req[idx] = '0; s_wr[idx] = '0; s_size[idx] = '0;
      s_addr[idx] = '0; s_wdata[idx] = '0;
      m_addr_ok[idx] = 1'b0; m_data_ok[idx] = 1'b0; m_rdata[idx] = '0;
      set_fields(idx, 0, 1'b0, 2'd2, 32'h1000_0000, 32'h0000_00D0);
      set_fields(idx, 1, 1'b1, 2'd1, 32'h2000_0000, 32'h0000_00D1);
      for (int c = 0; c < NCH; c++) acc[idx][c] = 1'b0;
    end
    #2 resetn = 1'b0;
    @(posedge clk); #1;

    // outputs stay quiet while reset is held even with activity on inputs
    applyStimulus(2'b11, 1'b1, 1'b1, 32'h55);
    settle_and_check();
    checkOutput("reset.m_req", 64'(m_req[0]), 64'd0);
    checkOutput("reset.s_addr_ok", 64'(s_addr_ok[0]), 64'd0);
    checkOutput("reset.s_data_ok", 64'(s_data_ok[1]), 64'd0);
    tick();
    resetn = 1'b1;

    // two channels requesting continuously, slave always ready
    do_reset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b11, 1'b1, (i > 0), DW'(i));
      settle_and_check();
      checkOutput($sformatf("rr_alt%0d", i), 64'(s_addr_ok[0]), (i % 2 == 0) ? 64'd1 : 64'd2);
      checkOutput($sformatf("fx_prio%0d", i), 64'(s_addr_ok[1]), 64'd1);
      tick();
    end

    // outstanding limit with no responses
    do_reset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b0, '0);
      settle_and_check();
      checkOutput($sformatf("limit_mreq%0d", i), 64'(m_req[0]), (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    applyStimulus(2'b01, 1'b1, 1'b1, 32'h77);
    settle_and_check();
    checkOutput("full_pop_mreq", 64'(m_req[0]), 64'd0);
    checkOutput("full_pop_dok", 64'(s_data_ok[0]), 64'd1);
    tick();
    applyStimulus(2'b01, 1'b1, 1'b0, '0);
    settle_and_check();
    checkOutput("after_pop_accept", 64'(s_addr_ok[0]), 64'd1);
    tick();
    settle_and_check();
    checkOutput("refull_mreq", 64'(m_req[0]), 64'd0);
    tick();

    // in-order response routing
    do_reset();
    applyStimulus(2'b10, 1'b1, 1'b0, '0);
    settle_and_check();
    checkOutput("order_acc1", 64'(s_addr_ok[0]), 64'd2);
    tick();
    applyStimulus(2'b01, 1'b1, 1'b0, '0);
    settle_and_check();
    checkOutput("order_acc0", 64'(s_addr_ok[0]), 64'd1);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h0000_AAAA);
    settle_and_check();
    checkOutput("order_dok_first", 64'(s_data_ok[0]), 64'd2);
    checkOutput("order_rdata_first", 64'(s_rdata[0]), 64'h0000_AAAA);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h0000_BBBB);
    settle_and_check();
    checkOutput("order_dok_second", 64'(s_data_ok[0]), 64'd1);
    checkOutput("order_rdata_second", 64'(s_rdata[0]), 64'h0000_BBBB);
    tick();

    // grant lock while the slave stalls
    do_reset();
    for (int idx = 0; idx < 2; idx++) set_fields(idx, 0, 1'b0, 2'd2, 32'h1234_5678, 32'hCAFE_0000);
    applyStimulus(2'b01, 1'b0, 1'b0, '0);
    settle_and_check();
    checkOutput("lock_addr_start", 64'(m_addr[0]), 64'h1234_5678);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b11, 1'b0, 1'b0, '0);
      settle_and_check();
      checkOutput($sformatf("lock_addr%0d", i), 64'(m_addr[0]), 64'h1234_5678);
      checkOutput($sformatf("lock_noacc%0d", i), 64'(s_addr_ok[0]), 64'd0);
      tick();
    end
    applyStimulus(2'b11, 1'b1, 1'b0, '0);
    settle_and_check();
    checkOutput("lock_accept_ch0", 64'(s_addr_ok[0]), 64'd1);
    tick();

    // granted channel withdrawing its request
    do_reset();
    applyStimulus(2'b10, 1'b0, 1'b0, '0);
    settle_and_check();
    tick();
    applyStimulus(2'b01, 1'b1, 1'b0, '0);
    settle_and_check();
    checkOutput("drop_regrant", 64'(s_addr_ok[0]), 64'd1);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, '0);
    settle_and_check();
    checkOutput("drop_err", 64'(err[0]), 64'd1);
    tick();

    // stray response with empty FIFO, then async reset mid-transaction
    do_reset();
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h99);
    settle_and_check();
    checkOutput("stray_dok", 64'(s_data_ok[0]), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 1'b0, 1'b0, '0);
      settle_and_check();
      checkOutput($sformatf("stray_err%0d", i), 64'(err[0]), 64'd1);
      tick();
    end
    applyStimulus(2'b01, 1'b1, 1'b0, '0);
    settle_and_check();
    tick();
    applyStimulus(2'b10, 1'b0, 1'b0, '0);
    settle_and_check();
    resetn = 1'b0;
    #1;
    checkOutput("async_count", 64'(dut_rr.fifo_count), 64'd0);
    checkOutput("async_err", 64'(err[0]), 64'd0);
    checkOutput("async_mreq", 64'(m_req[0]), 64'd0);
    tick();
    resetn = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h42);
    settle_and_check();
    checkOutput("late_dok", 64'(s_data_ok[0]), 64'd0);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, '0);
    settle_and_check();
    checkOutput("late_err", 64'(err[0]), 64'd1);
    tick();

    // random protocol-conforming traffic on both instances
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int idx = 0; idx < 2; idx++) begin
        for (int c = 0; c < NCH; c++) begin
          if (!(s_req[idx][c] && !acc[idx][c])) begin
            s_req[idx][c] = ($urandom_range(0, 2) != 0);
            set_fields(idx, c, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                       AW'($urandom), DW'($urandom));
          end
        end
        m_addr_ok[idx] = ($urandom_range(0, 3) != 0);
        if (qsz(idx) > 0) m_data_ok[idx] = 1'($urandom_range(0, 1));
        else m_data_ok[idx] = ($urandom_range(0, 63) == 0);
        m_rdata[idx] = DW'($urandom);
      end
      settle_and_check();
      for (int idx = 0; idx < 2; idx++)
        for (int c = 0; c < NCH; c++)
          acc[idx][c] = p_push[idx] && (p_g[idx] == c);
      tick();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
